border_io_tile: RTL and testbench
=================================

# border_io_tile

Parametrised perimeter tile for the overlay fabric. It joins up to IO_PER_CB device pins to the border routing tracks. It adds three things the fixed-width border tiles lack: double-buffered configuration with a checked commit, a per-pin registered or combinational mode, and per-pin output enables. It instantiates once per border position, rotated for the N/S/E/W edges, and sits on the same PCLK/SE/SIN/SOUT scan chain as the fabric switch and connection blocks.

## Interface
- BUS_WIDTH, 2, tracks per border direction
- IO_PER_CB, 1, device pins served by this tile
- Derived: SEL_W = $clog2(2*BUS_WIDTH+1); IDX_W = max(1,$clog2(IO_PER_CB)); CFG_W = IO_PER_CB*(SEL_W+2) + 2*BUS_WIDTH*(1+IDX_W), plus 1 when parity is enabled

- PCLK  in  1  fabric clock
- PRESETN  in  1  asynchronous active-low reset
- SE  in  1  scan enable; shift while high
- SIN  in  1  scan data in
- SOUT  out  1  scan data out (MSB of shadow register)
- CFG_DONE  out  1  sticky: last frame committed
- CFG_ERR  out  1  sticky: last frame rejected
- IO_IN  in  IO_PER_CB  pin input values
- IO_OUT  out  IO_PER_CB  pin output values
- IO_OE  out  IO_PER_CB  pin output enables
- WEST_BUS_IN, EAST_BUS_IN  in  BUS_WIDTH  incoming tracks
- WEST_BUS_OUT, EAST_BUS_OUT  out  BUS_WIDTH  outgoing tracks

## Operation
- **Shadow register** (CFG_W bits): on each PCLK edge with SE=1, shift left; SIN enters bit 0; SOUT = shadow[CFG_W-1].
- **Active register**: drives all routing. It changes only on commit.
- **Bit packing**, LSB first:
  - per pin i: OSEL[SEL_W], OREG, IREG
  - then per track j, EAST: EOVR, EIDX[IDX_W]
  - then per track j, WEST: WOVR, WIDX[IDX_W]
  - then parity, if enabled
- **Controller FSM**:
  - IDLE: SE=1 → SHIFT, count=1, clear CFG_DONE/CFG_ERR.
  - SHIFT: SE=1 → count++, saturating at CFG_W+1. SE=0 → CHECK.
  - CHECK (one cycle): if count==CFG_W (and parity is OK), copy shadow→active and set CFG_DONE; otherwise set CFG_ERR and leave active unchanged. Then → IDLE.
  - SE rising while in CHECK: the check completes first; SHIFT starts on the next edge.
- **Pin input path**: io_val[i] = IREG ? IO_IN registered once : IO_IN.
- **Pin output selection**:
  - OSEL=0 or >2*BUS_WIDTH: IO_OE=0, IO_OUT=0.
  - OSEL in 1..BUS_WIDTH: select WEST_BUS_IN[OSEL-1].
  - OSEL in BUS_WIDTH+1..2*BUS_WIDTH: select EAST_BUS_IN[OSEL-BUS_WIDTH-1].
  - For any non-zero valid selection, IO_OE=1.
  - IO_OUT = OREG ? registered selected value : selected value.
- **Tracks**:
  - EAST_BUS_OUT[j] = EOVR ? io_val[EIDX] : WEST_BUS_IN[j].
  - WEST_BUS_OUT[j] = WOVR ? io_val[WIDX] : EAST_BUS_IN[j].
  - An out-of-range index drives 0.
- **Reset**:
  - Shadow, active, pipeline registers and counter are cleared; FSM goes to IDLE.
  - CFG_DONE=0, CFG_ERR=0, SOUT=0, IO_OE=0, IO_OUT=0.
  - Buses are pure pass-through.
  - Reset mid-shift discards the partial frame.

## Timing
- Shift: one bit per PCLK edge with SE=1. A frame takes CFG_W edges.
- Commit: the active config and CFG_DONE/CFG_ERR update on the second edge after SE falls (the CHECK cycle).
- Combinational paths: bus pass-through and override with IREG=0. These are zero-latency.
- IREG=1 or OREG=1 adds exactly one PCLK cycle per stage. The two add (two cycles pin→pin through loopback).
- IO_OE is a pure function of active config; it changes only at commit or reset.
- During shifting the active config is untouched; routing keeps its previous behaviour.

## Configuration
- **BORDER_TILE_PARITY_EN**
  - Defined: CFG_W includes one trailing even-parity bit over the whole frame. CHECK additionally requires correct parity, and a mismatch sets CFG_ERR with no commit.
  - Undefined: there is no parity bit, and only the length check applies.

## Test plan
- **Reset**: with BUS_WIDTH=2, IO_PER_CB=1, assert PRESETN=0 mid-shift → IO_OE=0, IO_OUT=0, CFG_DONE=0, CFG_ERR=0, and WEST_BUS_IN=2'b10 appears on EAST_BUS_OUT.
- **Good frame**: shift exactly CFG_W bits with OSEL=3 (EAST[0]), OREG=0, then drop SE → CFG_DONE at SE-fall+2; EAST_BUS_IN[0] toggles reach IO_OUT the same cycle; IO_OE=1.
- **Short frame**: shift CFG_W-1 bits → CFG_ERR=1, CFG_DONE=0, routing unchanged. A following correct frame clears CFG_ERR.
- **Registered loopback**: IREG=1, OREG=1, EOVR[1]=1, EIDX=0; pulse IO_IN → EAST_BUS_OUT[1] follows one cycle later, and IO_OUT follows two cycles later when OSEL selects WEST[1] with externally looped tracks.
- **Scan through**: shift a 2*CFG_W-bit pattern → SOUT reproduces the first CFG_W bits delayed by CFG_W cycles.
- **Parity (BORDER_TILE_PARITY_EN)**: flip one data bit → CFG_ERR=1, no commit; correct parity → CFG_DONE=1.

Source files
------------

// File: rtl/border_io_tile.sv
// Perimeter I/O tile: scan-loaded shadow config, checked commit into the active
// config, per-pin registered/combinational paths. Macro BORDER_TILE_PARITY_EN adds frame parity.
module border_io_tile #(
  parameter int unsigned BUS_WIDTH = 2,
  parameter int unsigned IO_PER_CB = 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  input  logic                 SE,
  input  logic                 SIN,
  output logic                 SOUT,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR,
  input  logic [IO_PER_CB-1:0] IO_IN,
  output logic [IO_PER_CB-1:0] IO_OUT,
  output logic [IO_PER_CB-1:0] IO_OE,
  input  logic [BUS_WIDTH-1:0] WEST_BUS_IN,
  input  logic [BUS_WIDTH-1:0] EAST_BUS_IN,
  output logic [BUS_WIDTH-1:0] WEST_BUS_OUT,
  output logic [BUS_WIDTH-1:0] EAST_BUS_OUT
);

  localparam int unsigned SEL_W  = $clog2(2 * BUS_WIDTH + 1);
  localparam int unsigned IDX_W  = (IO_PER_CB > 1) ? $clog2(IO_PER_CB) : 1;
  localparam int unsigned PIN_W  = SEL_W + 2;
  localparam int unsigned TRK_W  = 1 + IDX_W;
  localparam int unsigned E_LSB  = IO_PER_CB * PIN_W;
  localparam int unsigned W_LSB  = E_LSB + BUS_WIDTH * TRK_W;
  localparam int unsigned DATA_W = W_LSB + BUS_WIDTH * TRK_W;
`ifdef BORDER_TILE_PARITY_EN
  localparam int unsigned CFG_W  = DATA_W + 1;
`else
  localparam int unsigned CFG_W  = DATA_W;
`endif
  localparam int unsigned CNT_W  = $clog2(CFG_W + 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IO_PER_CB-1:0] io_in_q, sel_q;
  logic [IO_PER_CB-1:0] io_val, sel_c, oe_c, io_out_c;
  logic [BUS_WIDTH-1:0] east_c, west_c;
  logic               len_ok, par_ok;

  assign len_ok = (cnt_q == CNT_W'(CFG_W));
`ifdef BORDER_TILE_PARITY_EN
  assign par_ok = ~(^shadow_q);
`else
  assign par_ok = 1'b1;
`endif

  // State and pipeline registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      io_in_q  <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      io_in_q  <= IO_IN;
      sel_q    <= sel_c;
    end
  end

  // Frame controller: count shifted bits, check length (and parity) one cycle after SE falls
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = SE ? {shadow_q[CFG_W-2:0], SIN} : shadow_q;
    active_d = active_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (SE) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_W'(1);
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (SE) begin
          if (cnt_q != CNT_W'(CFG_W + 1)) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (len_ok && par_ok) begin
          active_d = shadow_q;
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Routing decoded from the active config
  always_comb begin
    logic [SEL_W-1:0] osel;
    logic             oreg;
    logic [IDX_W-1:0] idx;
    io_val   = '0;
    sel_c    = '0;
    oe_c     = '0;
    io_out_c = '0;
    east_c   = '0;
    west_c   = '0;
    osel     = '0;
    oreg     = 1'b0;
    idx      = '0;
    for (int i = 0; i < IO_PER_CB; i++) begin
      osel      = active_q[i*PIN_W +: SEL_W];
      oreg      = active_q[i*PIN_W + SEL_W];
      io_val[i] = active_q[i*PIN_W + SEL_W + 1] ? io_in_q[i] : IO_IN[i];
      for (int b = 0; b < BUS_WIDTH; b++) begin
        if (osel == SEL_W'(b + 1))             sel_c[i] = WEST_BUS_IN[b];
        if (osel == SEL_W'(b + 1 + BUS_WIDTH)) sel_c[i] = EAST_BUS_IN[b];
      end
      oe_c[i]     = (osel != '0) && (osel <= SEL_W'(2 * BUS_WIDTH));
      io_out_c[i] = oe_c[i] & (oreg ? sel_q[i] : sel_c[i]);
    end
    // An index beyond IO_PER_CB matches no pin and leaves the track at 0
    for (int j = 0; j < BUS_WIDTH; j++) begin
      east_c[j] = WEST_BUS_IN[j];
      if (active_q[E_LSB + j*TRK_W]) begin
        idx       = active_q[E_LSB + j*TRK_W + 1 +: IDX_W];
        east_c[j] = 1'b0;
        for (int k = 0; k < IO_PER_CB; k++)
          if (idx == IDX_W'(k)) east_c[j] = io_val[k];
      end
      west_c[j] = EAST_BUS_IN[j];
      if (active_q[W_LSB + j*TRK_W]) begin
        idx       = active_q[W_LSB + j*TRK_W + 1 +: IDX_W];
        west_c[j] = 1'b0;
        for (int k = 0; k < IO_PER_CB; k++)
          if (idx == IDX_W'(k)) west_c[j] = io_val[k];
      end
    end
  end

  assign SOUT         = shadow_q[CFG_W-1];
  assign CFG_DONE     = done_q;
  assign CFG_ERR      = err_q;
  assign IO_OE        = oe_c;
  assign IO_OUT       = io_out_c;
  assign EAST_BUS_OUT = east_c;
  assign WEST_BUS_OUT = west_c;

endmodule

// File: tb/tb_border_io_tile.sv
// Self-checking bench for border_io_tile (BUS_WIDTH=2, IO_PER_CB=1): a frame-level
// model is compared every cycle, plus directed literal expectations.
module tb_border_io_tile;

  localparam int BW     = 2;
  localparam int IOP    = 1;
  localparam int SEL_W  = $clog2(2 * BW + 1);
  localparam int IDX_W  = (IOP > 1) ? $clog2(IOP) : 1;
  localparam int PIN_W  = SEL_W + 2;
  localparam int TRK_W  = 1 + IDX_W;
  localparam int E_LSB  = IOP * PIN_W;
  localparam int W_LSB  = E_LSB + BW * TRK_W;
  localparam int DATA_W = W_LSB + BW * TRK_W;
`ifdef BORDER_TILE_PARITY_EN
  localparam int CFG_W  = DATA_W + 1;
`else
  localparam int CFG_W  = DATA_W;
`endif

  localparam int L_OUT = 0, L_OE = 1, L_DONE = 2, L_ERR = 3, L_EAST = 4, L_WEST = 5, L_SOUT = 6;

  logic PCLK = 1'b0, PRESETN = 1'b0, SE = 1'b0, SIN = 1'b0;
  logic [IOP-1:0] io_in = '0;
  logic [BW-1:0]  west_in = '0, east_in = '0;
  wire  [IOP-1:0] io_out, io_oe;
  wire  [BW-1:0]  east_out, west_out;
  wire            sout, cfg_done, cfg_err;

  int    n_cmp = 0, n_bad = 0;
  logic  chk_on = 1'b0, loop_en = 1'b0;
  logic  lit_en = 1'b0;
  int    lit_sig = 0, lit_exp = 0;
  string lit_name = "";

  // Model state
  logic [CFG_W-1:0] m_act = '0, m_sh = '0;
  logic [IOP-1:0]   m_prev_in = '0, m_prev_sel = '0;
  logic             m_done = 1'b0, m_err = 1'b0, m_in_frame = 1'b0, m_pending = 1'b0;
  int               m_len = 0;

  border_io_tile #(.BUS_WIDTH(BW), .IO_PER_CB(IOP)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .SE(SE), .SIN(SIN), .SOUT(sout),
    .CFG_DONE(cfg_done), .CFG_ERR(cfg_err),
    .IO_IN(io_in), .IO_OUT(io_out), .IO_OE(io_oe),
    .WEST_BUS_IN(west_in), .EAST_BUS_IN(east_in),
    .WEST_BUS_OUT(west_out), .EAST_BUS_OUT(east_out)
  );

  always #5 PCLK = ~PCLK;

  function automatic int fld(input logic [CFG_W-1:0] v, input int lsb, input int w);
    int r;
    r = 0;
    for (int b = 0; b < w; b++) if (v[lsb + b]) r += (1 << b);
    return r;
  endfunction

  function automatic logic sel_of(input logic [CFG_W-1:0] a, input int i,
                                  input logic [BW-1:0] w, input logic [BW-1:0] e);
    int s;
    s = fld(a, i * PIN_W, SEL_W);
    if (s >= 1 && s <= BW) return w[s - 1];
    if (s > BW && s <= 2 * BW) return e[s - BW - 1];
    return 1'b0;
  endfunction

  function automatic logic [IOP-1:0] sel_vec(input logic [CFG_W-1:0] a,
                                             input logic [BW-1:0] w, input logic [BW-1:0] e);
    logic [IOP-1:0] r;
    for (int i = 0; i < IOP; i++) r[i] = sel_of(a, i, w, e);
    return r;
  endfunction

  function automatic logic parity_ok(input logic [CFG_W-1:0] v);
`ifdef BORDER_TILE_PARITY_EN
    return (^v) == 1'b0;
`else
    return (v == v);
`endif
  endfunction

  function automatic logic [CFG_W-1:0] mk(input int osel, input logic oreg, input logic ireg,
      input logic [BW-1:0] eovr, input logic [BW*IDX_W-1:0] eidx,
      input logic [BW-1:0] wovr, input logic [BW*IDX_W-1:0] widx);
    logic [CFG_W-1:0] v;
    v = '0;
    for (int b = 0; b < SEL_W; b++) v[b] = osel[b];
    v[SEL_W]     = oreg;
    v[SEL_W + 1] = ireg;
    for (int j = 0; j < BW; j++) begin
      v[E_LSB + j*TRK_W] = eovr[j];
      v[W_LSB + j*TRK_W] = wovr[j];
      for (int b = 0; b < IDX_W; b++) begin
        v[E_LSB + j*TRK_W + 1 + b] = eidx[j*IDX_W + b];
        v[W_LSB + j*TRK_W + 1 + b] = widx[j*IDX_W + b];
      end
    end
`ifdef BORDER_TILE_PARITY_EN
    v[CFG_W-1] = ^v[DATA_W-1:0];
`endif
    return v;
  endfunction

  // Frame-level model: bits in, length/parity judged one edge after SE drops
  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      m_act <= '0; m_sh <= '0; m_prev_in <= '0; m_prev_sel <= '0;
      m_done <= 1'b0; m_err <= 1'b0; m_in_frame <= 1'b0; m_pending <= 1'b0; m_len <= 0;
    end else begin
      m_prev_in  <= io_in;
      m_prev_sel <= sel_vec(m_act, west_in, east_in);
      if (SE) m_sh <= {m_sh[CFG_W-2:0], SIN};
      if (m_pending) begin
        m_pending <= 1'b0;
        if (m_len == CFG_W && parity_ok(m_sh)) begin
          m_act  <= m_sh;
          m_done <= 1'b1;
        end else begin
          m_err <= 1'b1;
        end
      end else if (SE) begin
        if (!m_in_frame) begin
          m_in_frame <= 1'b1; m_len <= 1; m_done <= 1'b0; m_err <= 1'b0;
        end else begin
          m_len <= m_len + 1;
        end
      end else if (m_in_frame) begin
        m_in_frame <= 1'b0;
        m_pending  <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 'h%0h, want 'h%0h", nm, $time, act, exp);
    end
  endtask

  // Compare process: all outputs every cycle, plus any pending literal
  always @(negedge PCLK) begin : cmp_p
    logic [IOP-1:0] iov, e_oe, e_out;
    logic [BW-1:0]  e_e, e_w;
    int s, ix, lv;
    if (chk_on) begin
      for (int i = 0; i < IOP; i++) begin
        iov[i]   = (fld(m_act, i*PIN_W + SEL_W + 1, 1) != 0) ? m_prev_in[i] : io_in[i];
        s        = fld(m_act, i*PIN_W, SEL_W);
        e_oe[i]  = (s >= 1 && s <= 2 * BW);
        e_out[i] = e_oe[i] & ((fld(m_act, i*PIN_W + SEL_W, 1) != 0) ? m_prev_sel[i]
                                                                     : sel_of(m_act, i, west_in, east_in));
      end
      for (int j = 0; j < BW; j++) begin
        ix     = fld(m_act, E_LSB + j*TRK_W + 1, IDX_W);
        e_e[j] = (fld(m_act, E_LSB + j*TRK_W, 1) != 0) ? ((ix < IOP) ? iov[ix] : 1'b0) : west_in[j];
        ix     = fld(m_act, W_LSB + j*TRK_W + 1, IDX_W);
        e_w[j] = (fld(m_act, W_LSB + j*TRK_W, 1) != 0) ? ((ix < IOP) ? iov[ix] : 1'b0) : east_in[j];
      end
      chk("io_out",   int'(io_out),   int'(e_out));
      chk("io_oe",    int'(io_oe),    int'(e_oe));
      chk("east_out", int'(east_out), int'(e_e));
      chk("west_out", int'(west_out), int'(e_w));
      chk("cfg_done", int'(cfg_done), int'(m_done));
      chk("cfg_err",  int'(cfg_err),  int'(m_err));
      chk("sout",     int'(sout),     int'(m_sh[CFG_W-1]));
      if (lit_en) begin
        case (lit_sig)
          L_OUT:   lv = int'(io_out);
          L_OE:    lv = int'(io_oe);
          L_DONE:  lv = int'(cfg_done);
          L_ERR:   lv = int'(cfg_err);
          L_EAST:  lv = int'(east_out);
          L_WEST:  lv = int'(west_out);
          default: lv = int'(sout);
        endcase
        chk(lit_name, lv, lit_exp);
      end
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
    if (loop_en) west_in[1] = east_out[1];
    lit_en = 1'b0;
  endtask

  task automatic lit(input int sig, input int exp, input string nm);
    lit_en = 1'b1; lit_sig = sig; lit_exp = exp; lit_name = nm;
  endtask

  task automatic send_bits(input logic [CFG_W-1:0] f, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      SE  = 1'b1;
      SIN = (k < CFG_W) ? f[k] : 1'b0;
      step();
    end
  endtask

  task automatic finish_frame(input logic ok);
    SE = 1'b0;
    step();
    lit(L_DONE, 0, "done_fall_plus1");
    step();
    lit(L_DONE, ok ? 1 : 0, "done_fall_plus2");
    step();
    lit(L_ERR, ok ? 0 : 1, "err_after_check");
    step();
  endtask

  initial begin : stim
    logic [CFG_W-1:0]   f;
    logic [2*CFG_W-1:0] pat;
    repeat (2) @(posedge PCLK);
    #1;
    chk_on = 1'b1;
    lit(L_OE, 0, "rst_oe"); step();
    lit(L_SOUT, 0, "rst_sout"); step();
    PRESETN = 1'b1;
    west_in = 2'b01;
    lit(L_EAST, 1, "rst_pass"); step();

    // Good frame: OSEL=3 selects EAST[0], combinational
    send_bits(mk(3, 1'b0, 1'b0, '0, '0, '0, '0), CFG_W);
    finish_frame(1'b1);
    east_in = 2'b01; lit(L_OUT, 1, "osel3_hi"); step();
    east_in = 2'b10; lit(L_OUT, 0, "osel3_lo"); step();
    lit(L_OE, 1, "osel3_oe"); step();

    // Reset in the middle of a shift
    send_bits(mk(4, 1'b0, 1'b0, '0, '0, '0, '0), 5);
    PRESETN = 1'b0; SE = 1'b0; west_in = 2'b10;
    lit(L_EAST, 2, "rst_mid_pass"); step();
    lit(L_OE, 0, "rst_mid_oe"); step();
    lit(L_OUT, 0, "rst_mid_out"); step();
    PRESETN = 1'b1;
    lit(L_DONE, 0, "rst_mid_done"); step();
    step();

    // Registered output, then short and long frames leave routing alone
    send_bits(mk(1, 1'b1, 1'b0, '0, '0, '0, '0), CFG_W);
    finish_frame(1'b1);
    west_in = 2'b01; lit(L_OUT, 0, "oreg_lag"); step();
    lit(L_OUT, 1, "oreg_1cyc"); step();
    send_bits(mk(3, 1'b0, 1'b0, '0, '0, '0, '0), CFG_W - 1);
    finish_frame(1'b0);
    lit(L_OE, 1, "short_keeps_oe"); step();
    send_bits(mk(3, 1'b0, 1'b0, '0, '0, '0, '0), CFG_W + 3);
    finish_frame(1'b0);
    send_bits(mk(4, 1'b0, 1'b0, '0, '0, '0, '0), CFG_W);
    finish_frame(1'b1);
    east_in = 2'b10; lit(L_OUT, 1, "osel4_e1"); step();

    // Combinational override; WIDX=1 is out of range, OSEL=6 is invalid
    send_bits(mk(6, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b10), CFG_W);
    finish_frame(1'b1);
    west_in = 2'b00; east_in = 2'b11; io_in = 1'b1;
    lit(L_EAST, 1, "ovr_e0_hi"); step();
    lit(L_WEST, 1, "ovr_w1_oor"); step();
    io_in = 1'b0; lit(L_EAST, 0, "ovr_e0_lo"); step();
    lit(L_OE, 0, "osel6_oe"); step();

    // Registered loopback through EAST[1] -> WEST[1]
    send_bits(mk(2, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00), CFG_W);
    finish_frame(1'b1);
    loop_en = 1'b1; step(); step();
    io_in = 1'b1; lit(L_EAST, 0, "lb_pre"); step();
    io_in = 1'b0; lit(L_EAST, 2, "lb_e1_1cyc"); step();
    lit(L_OUT, 1, "lb_out_2cyc"); step();
    lit(L_OUT, 0, "lb_out_back"); step();
    loop_en = 1'b0;

    // Scan-through of a 2*CFG_W pattern
    for (int b = 0; b < 2 * CFG_W; b++) pat[b] = 1'($urandom_range(0, 1));
    pat[0] = 1'b1; pat[CFG_W-1] = 1'b1;
    for (int n = 0; n < 2 * CFG_W; n++) begin
      SE = 1'b1; SIN = pat[n];
      if (n == CFG_W) lit(L_SOUT, 1, "scan_first");
      if (n == 2 * CFG_W - 1) lit(L_SOUT, 1, "scan_last");
      step();
    end
    finish_frame(1'b0);

`ifdef BORDER_TILE_PARITY_EN
    f = mk(3, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    f[1] = ~f[1];
    send_bits(f, CFG_W);
    finish_frame(1'b0);
    f[1] = ~f[1];
    send_bits(f, CFG_W);
    finish_frame(1'b1);
`else
    f = mk(0, 1'b0, 1'b0, '0, '0, '0, '0);
    send_bits(f, CFG_W);
    finish_frame(1'b1);
`endif
    lit(L_OE, int'(fld(f, 0, SEL_W) != 0 && fld(f, 0, SEL_W) <= 2 * BW), "final_oe"); step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
